// File: rtl/lcb_req_responder_if.sv
// Byte-link bundle between the LCB request responder and its receiver,
// sample RAM, transmitter and RS485 direction control.
interface lcb_req_responder_if;
  logic       iValid;
  logic [7:0] iData;
  logic [8:0] oRdAddr;
  logic [7:0] iRdData;
  logic [7:0] oTxData;
  logic       oTxStart;
  logic       iTxBusy;
  logic       oDirTX;
  logic       oDirRX;
  logic [4:0] oChan;
  logic       oReqErr;

  modport slave (
    input  iValid, iData, iRdData, iTxBusy,
    output oRdAddr, oTxData, oTxStart, oDirTX, oDirRX, oChan, oReqErr
  );

  modport master (
    output iValid, iData, iRdData, iTxBusy,
    input  oRdAddr, oTxData, oTxStart, oDirTX, oDirRX, oChan, oReqErr
  );
endinterface

// File: rtl/lcb_req_responder.sv
// LCB responder: parses 4-byte requests (addr, cmd, chan, xor checksum) and, after a
// turnaround, streams RESP_BYTES sample bytes of the requested channel over half-duplex RS485.
module lcb_req_responder #(
  parameter logic [7:0]  MY_ADDR     = 8'h01,
  parameter int unsigned RESP_BYTES  = 6,
  parameter int unsigned TURN_CYC    = 400,
  parameter int unsigned GUARD_CYC   = 80,
  parameter int unsigned GAP_TIMEOUT = 2000
) (
  input logic           clk,
  input logic           reset,
  lcb_req_responder_if.slave bus
);

  localparam logic [7:0] CMD_READ = 8'h5A;

  typedef enum logic [2:0] {
    S_RX, S_TURN, S_PRE, S_FETCH, S_LOAD, S_SEND, S_WAITB, S_POST
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [3:0][7:0] pkt_q, pkt_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     tmr_q, tmr_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      chan_q, chan_d;
  logic [7:0]      txd_q, txd_d;
  logic [2:0]      bidx;
  logic            reqerr;
  logic [15:0]     tmr_sat, gap_sat;
  logic [31:0]     tmr_ext;

  assign tmr_sat = (tmr_q == '1) ? tmr_q : tmr_q + 16'd1;
  assign gap_sat = (gap_q == '1) ? gap_q : gap_q + 16'd1;
  assign tmr_ext = {16'd0, tmr_q} + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RX;
      bcnt_q  <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      tmr_q   <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    tmr_d   = tmr_sat;
    idx_d   = idx_q;
    chan_d  = chan_q;
    txd_d   = txd_q;
    bidx    = bcnt_q;
    reqerr  = 1'b0;
    case (state_q)
      S_RX: begin
        tmr_d = '0;
        // Complete packet is judged one clk after B3; that slot absorbs the +4 latency
        // and a byte arriving in it is not collected.
        if (bcnt_q == 3'd4) begin
          bcnt_d = '0;
          gap_d  = '0;
          if (pkt_q[0] == MY_ADDR) begin
            if (pkt_q[3] != (pkt_q[0] ^ pkt_q[1] ^ pkt_q[2])) begin
              reqerr = 1'b1;
            end else if (pkt_q[1] == CMD_READ) begin
              chan_d  = pkt_q[2][4:0];
              idx_d   = '0;
              state_d = S_TURN;
            end
          end
        end else begin
          if (bcnt_q != 3'd0 && {16'd0, gap_q} >= GAP_TIMEOUT) begin
            bidx   = '0;
            bcnt_d = '0;
            gap_d  = '0;
          end else if (bcnt_q != 3'd0) begin
            gap_d = gap_sat;
          end
          if (bus.iValid) begin
            pkt_d[bidx[1:0]] = bus.iData;
            bcnt_d           = bidx + 3'd1;
            gap_d            = '0;
          end
        end
      end
      S_TURN: begin
        if (tmr_ext >= TURN_CYC) begin
          tmr_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (tmr_ext >= GUARD_CYC) begin
          tmr_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        txd_d   = bus.iRdData;
        state_d = S_SEND;
      end
      S_SEND: begin
        tmr_d   = '0;
        state_d = S_WAITB;
      end
      S_WAITB: begin
        // First WAITB clk is skipped: busy only rises the clk after the start strobe.
        if (tmr_q != '0 && !bus.iTxBusy) begin
          tmr_d = '0;
          if (idx_q == 4'(RESP_BYTES - 1)) begin
            state_d = S_POST;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_POST: begin
        if (tmr_ext >= GUARD_CYC) begin
          tmr_d   = '0;
          bcnt_d  = '0;
          gap_d   = '0;
          state_d = S_RX;
        end
      end
      default: state_d = S_RX;
    endcase
  end

  assign bus.oRdAddr  = {chan_q, idx_q};
  assign bus.oTxData  = txd_q;
  assign bus.oTxStart = (state_q == S_SEND);
  assign bus.oDirTX   = (state_q != S_RX) && (state_q != S_TURN);
  assign bus.oDirRX   = bus.oDirTX;
  assign bus.oChan    = chan_q;
  assign bus.oReqErr  = reqerr;

endmodule

// File: tb/tb_lcb_req_responder.sv
// Directed bench for lcb_req_responder with a registered sample RAM and a simple
// transmitter busy model; responses are captured at negedge and compared per scenario.
module tb_lcb_req_responder;
  localparam int unsigned T   = 10;
  localparam int unsigned G   = 5;
  localparam int unsigned GAP = 20;
  localparam int unsigned NB  = 6;
  localparam int unsigned TXB = 8;
  localparam int unsigned DIRHI = 2 * G + NB * (3 + TXB + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  lcb_req_responder_if bus_if();

  lcb_req_responder #(
    .MY_ADDR(8'h01), .RESP_BYTES(NB), .TURN_CYC(T), .GUARD_CYC(G), .GAP_TIMEOUT(GAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [512];
  logic [7:0] rd_q = '0;
  int         busy_cnt = 0;

  function automatic logic [7:0] ramv(input int a);
    return 8'((a * 13 + 5) & 255);
  endfunction

  initial for (int a = 0; a < 512; a++) ram[a] = ramv(a);
  always @(posedge clk) rd_q <= ram[bus_if.oRdAddr];
  always @(posedge clk) begin
    if (bus_if.oTxStart) busy_cnt <= TXB;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus_if.iRdData = rd_q;
  assign bus_if.iTxBusy = (busy_cnt != 0);

  logic [7:0] txq[$];
  int         txcyc[$];
  int         reqerr_cnt = 0, dir_hi_cnt = 0, dirrx_bad = 0, dir_rise_cyc = 0;
  logic       dir_prev = 1'b0;
  int         last_strobe = 0;

  always @(negedge clk) begin
    if (bus_if.oTxStart === 1'b1) begin
      txq.push_back(bus_if.oTxData);
      txcyc.push_back(cyc);
    end
    if (bus_if.oReqErr === 1'b1) reqerr_cnt++;
    if (bus_if.oDirTX === 1'b1) dir_hi_cnt++;
    if (bus_if.oDirTX === 1'b1 && !dir_prev) dir_rise_cyc = cyc;
    dir_prev = bus_if.oDirTX;
    if (bus_if.oDirRX !== bus_if.oDirTX) dirrx_bad++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_if.iValid = 1'b1;
    bus_if.iData  = b;
    last_strobe   = cyc;
    @(negedge clk);
    bus_if.iValid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (txq.size() >= base + int'(NB) && bus_if.oDirTX === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    idle(2);
    n_tests++;
    if ({bus_if.oTxStart, bus_if.oDirTX, bus_if.oDirRX, bus_if.oReqErr} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0000",
        {bus_if.oTxStart, bus_if.oDirTX, bus_if.oDirRX, bus_if.oReqErr});
    end
    n_tests++;
    if ({bus_if.oRdAddr, bus_if.oTxData, bus_if.oChan} !== 22'd0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {bus_if.oRdAddr, bus_if.oTxData, bus_if.oChan});
    end
    @(negedge clk); reset = 1'b0;
    idle(3);
    n_tests++;
    if (bus_if.oDirTX !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_dir got %b want 0", bus_if.oDirTX);
    end
  endtask

  task automatic test_read;
    int base = txq.size();
    int err0 = reqerr_cnt, dh0 = dir_hi_cnt, dr0 = dirrx_bad;
    int strobe;
    bit ok;
    send_pkt(8'h01, 8'h5A, 8'h03, 8'h58);
    strobe = last_strobe;
    wait_done(base, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL read_timeout got %0d starts want %0d", txq.size() - base, NB); end
    n_tests++;
    if (txq.size() - base !== NB) begin n_fail++; $display("FAIL read_count got %0d want %0d", txq.size() - base, NB); end
    for (int k = 0; k < int'(NB); k++) begin
      logic [7:0] got = (base + k < txq.size()) ? txq[base + k] : 8'hxx;
      n_tests++;
      if (got !== ramv(9'h030 + k)) begin
        n_fail++; $display("FAIL read_byte%0d got %h want %h", k, got, ramv(9'h030 + k));
      end
    end
    n_tests++;
    if (base < txq.size() && txcyc[base] - strobe !== int'(T + G + 4)) begin
      n_fail++; $display("FAIL read_latency got %0d want %0d", txcyc[base] - strobe, T + G + 4);
    end
    n_tests++;
    if (dir_rise_cyc - strobe !== int'(T + 2)) begin
      n_fail++; $display("FAIL read_dir_rise got %0d want %0d", dir_rise_cyc - strobe, T + 2);
    end
    n_tests++;
    if (dir_hi_cnt - dh0 !== int'(DIRHI)) begin
      n_fail++; $display("FAIL read_dir_len got %0d want %0d", dir_hi_cnt - dh0, DIRHI);
    end
    n_tests++;
    if (bus_if.oChan !== 5'd3) begin n_fail++; $display("FAIL read_chan got %0d want 3", bus_if.oChan); end
    n_tests++;
    if (reqerr_cnt - err0 !== 0 || dirrx_bad - dr0 !== 0) begin
      n_fail++; $display("FAIL read_side got err %0d dirrx %0d want 0 0", reqerr_cnt - err0, dirrx_bad - dr0);
    end
  endtask

  task automatic test_bad_csum;
    int base = txq.size(), err0 = reqerr_cnt, dh0 = dir_hi_cnt;
    send_pkt(8'h01, 8'h5A, 8'h03, 8'h59);
    idle(60);
    n_tests++;
    if (reqerr_cnt - err0 !== 1) begin n_fail++; $display("FAIL csum_reqerr got %0d want 1", reqerr_cnt - err0); end
    n_tests++;
    if (txq.size() - base !== 0 || dir_hi_cnt - dh0 !== 0) begin
      n_fail++; $display("FAIL csum_quiet got starts %0d dir %0d want 0 0", txq.size() - base, dir_hi_cnt - dh0);
    end
  endtask

  task automatic test_drop;
    int base = txq.size(), err0 = reqerr_cnt;
    send_pkt(8'h02, 8'h5A, 8'h03, 8'h5B);
    idle(60);
    n_tests++;
    if (txq.size() - base !== 0 || reqerr_cnt - err0 !== 0) begin
      n_fail++; $display("FAIL other_addr got starts %0d err %0d want 0 0", txq.size() - base, reqerr_cnt - err0);
    end
    send_pkt(8'h01, 8'h33, 8'h03, 8'h31);
    idle(60);
    n_tests++;
    if (txq.size() - base !== 0 || reqerr_cnt - err0 !== 0) begin
      n_fail++; $display("FAIL bad_cmd got starts %0d err %0d want 0 0", txq.size() - base, reqerr_cnt - err0);
    end
  endtask

  task automatic test_gap(input int idle_n, input logic [4:0] ch, input logic [7:0] ck, input string nm);
    int base;
    bit ok;
    send_byte(8'h01); send_byte(8'h5A);
    base = txq.size();
    repeat (idle_n) @(negedge clk);
    bus_if.iValid = 1'b1; bus_if.iData = 8'h01;
    @(negedge clk);
    bus_if.iValid = 1'b0;
    send_byte(8'h5A); send_byte({3'b000, ch}); send_byte(ck);
    wait_done(base, ok);
    n_tests++;
    if (ok !== 1'b1 || bus_if.oChan !== ch) begin
      n_fail++; $display("FAIL %s_chan got %0d (done %0d) want %0d", nm, bus_if.oChan, ok, ch);
    end
    for (int k = 0; k < int'(NB); k++) begin
      logic [7:0] got = (base + k < txq.size()) ? txq[base + k] : 8'hxx;
      n_tests++;
      if (got !== ramv({ch, 4'(k)})) begin
        n_fail++; $display("FAIL %s_byte%0d got %h want %h", nm, k, got, ramv({ch, 4'(k)}));
      end
    end
    idle(20);
  endtask

  task automatic test_reset_mid;
    int base = txq.size();
    bit ok = 1'b0;
    send_pkt(8'h01, 8'h5A, 8'h03, 8'h58);
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (txq.size() >= base + 3);
    end
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach got %0d starts want 3", txq.size() - base); end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.oDirTX, bus_if.oDirRX, bus_if.oTxStart, bus_if.oChan} !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_outputs got %b want 0",
        {bus_if.oDirTX, bus_if.oDirRX, bus_if.oTxStart, bus_if.oChan});
    end
    @(negedge clk); reset = 1'b0;
    idle(15);
    base = txq.size();
    send_pkt(8'h01, 8'h5A, 8'h06, 8'h5D);
    wait_done(base, ok);
    n_tests++;
    if (ok !== 1'b1 || bus_if.oChan !== 5'd6 || txq.size() - base !== NB) begin
      n_fail++; $display("FAIL rstmid_after got chan %0d starts %0d want 6 %0d", bus_if.oChan, txq.size() - base, NB);
    end
    n_tests++;
    if (base + 5 < txq.size() && txq[base + 5] !== ramv(9'h065)) begin
      n_fail++; $display("FAIL rstmid_last got %h want %h", txq[base + 5], ramv(9'h065));
    end
    idle(20);
  endtask

  task automatic test_back_to_back;
    int base = txq.size(), err0 = reqerr_cnt;
    bit ok = 1'b0;
    send_pkt(8'h01, 8'h5A, 8'h03, 8'h58);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (bus_if.oDirTX === 1'b1);
    end
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h07);
    wait_done(base, ok);
    n_tests++;
    if (ok !== 1'b1 || txq.size() - base !== NB || bus_if.oChan !== 5'd3) begin
      n_fail++; $display("FAIL hd_first got chan %0d starts %0d want 3 %0d", bus_if.oChan, txq.size() - base, NB);
    end
    base = txq.size();
    send_pkt(8'h01, 8'h5A, 8'h07, 8'h5C);
    wait_done(base, ok);
    n_tests++;
    if (ok !== 1'b1 || bus_if.oChan !== 5'd7 || reqerr_cnt - err0 !== 0) begin
      n_fail++; $display("FAIL hd_next got chan %0d err %0d want 7 0", bus_if.oChan, reqerr_cnt - err0);
    end
    n_tests++;
    if (base < txq.size() && txq[base] !== ramv(9'h070)) begin
      n_fail++; $display("FAIL hd_next_byte0 got %h want %h", txq[base], ramv(9'h070));
    end
  endtask

  initial begin
    bus_if.iValid = 1'b0;
    bus_if.iData  = '0;
    test_reset();
    test_read();
    test_bad_csum();
    test_drop();
    test_gap(int'(GAP) + 1, 5'd4, 8'h5F, "gap_timeout");
    test_gap(int'(GAP), 5'd5, 8'h5E, "gap_same_clk");
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
